shl_seq: RTL and testbench

//   Multi-cycle logical left shifter; the left-shift counterpart of the datapath SHR component.

---
 rtl/shl_seq.sv | 125 ++++++++++++
 tb/tb_shl_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shl_seq.sv
// ---------------------------------------------------------------------------
// shl_seq : multi-cycle logical left shifter.
//
// The operand is shifted left by one bit on each clock, so no combinational
// barrel shifter is needed. The result register d is written only when an
// operation completes. It holds its value until the next completion or reset.
//
// Ports
//   Clk        in   1          rising-edge clock
//   Rst        in   1          asynchronous, active-low reset
//   start      in   1          request, sampled only while idle
//   a          in   DATAWIDTH  operand, captured on an accepted start
//   sh_amt     in   DATAWIDTH  unsigned shift amount, captured on an accepted start
//   busy       out  1          high whenever the FSM is not idle
//   done       out  1          one-cycle pulse, d holds a new result
//   d          out  DATAWIDTH  registered result a << sh_amt (zero fill)
//   dbg_state  out  2          current FSM state (0 idle, 1 shift, 2 done)
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0. start is ignored while busy=1; it is neither queued nor allowed to
// disturb an operation in flight. done pulses for exactly one cycle, and busy
// falls on the edge after that pulse. busy and done are registers, so there
// is no combinational path from start to either output.
// ---------------------------------------------------------------------------
module shl_seq #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] d,
  output logic [1:0]           dbg_state
);

  // The counter must be able to hold the value DATAWIDTH itself.
  localparam int CW = $clog2(DATAWIDTH + 1);

  localparam logic [DATAWIDTH-1:0] W_DW_OPND = DATAWIDTH'(DATAWIDTH);
  localparam logic [CW-1:0]        W_DW_CNT  = CW'(DATAWIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATAWIDTH-1:0]  r_sreg;
  logic [CW-1:0]         r_cnt;
  logic [DATAWIDTH-1:0]  r_d;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_clamp;
  logic [CW-1:0]         w_n;

  // Any amount of DATAWIDTH or more shifts every bit out, so it is clamped to
  // DATAWIDTH. An unclamped amount is below DATAWIDTH and therefore fits in CW
  // bits.
  assign w_clamp = (sh_amt >= W_DW_OPND);
  assign w_n     = w_clamp ? W_DW_CNT : sh_amt[CW-1:0];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sreg <= a;
            r_cnt  <= w_n;
            r_busy <= 1'b1;
            if (w_n == '0) begin
              // A zero-length shift completes at once with the operand unchanged.
              r_state <= S_DONE;
              r_d     <= a;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          r_sreg <= r_sreg << 1;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            // The last shift goes straight into d, so d is written only at
            // completion.
            r_state <= S_DONE;
            r_d     <= r_sreg << 1;
            r_done  <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign d         = r_d;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_shl_seq.sv
// ---------------------------------------------------------------------------
// tb_shl_seq : self-checking bench for shl_seq.
//
// The reference model tracks each accepted operation as a count of remaining
// busy cycles and a pending result. The result is computed arithmetically as
// a * 2^N, truncated to the operand width. Outputs are compared against the
// model on every falling edge. Directed cases add literal expectations. A
// second instance with DATAWIDTH=2 covers the narrow-width cases.
// ---------------------------------------------------------------------------
module tb_shl_seq;

  localparam int W = 8;

  // clock / reset
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  // DUT (DATAWIDTH = 8)
  logic         start  = 1'b0;
  logic [W-1:0] a      = '0;
  logic [W-1:0] sh_amt = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic [1:0]   dbg_state;

  shl_seq #(.DATAWIDTH(W)) u_dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start),
    .a         (a),
    .sh_amt    (sh_amt),
    .busy      (busy),
    .done      (done),
    .d         (d),
    .dbg_state (dbg_state)
  );

  // DUT (DATAWIDTH = 2)
  logic       start2 = 1'b0;
  logic [1:0] a2     = '0;
  logic [1:0] sh2    = '0;
  logic       busy2;
  logic       done2;
  logic [1:0] d2;
  logic [1:0] dbg2;

  shl_seq #(.DATAWIDTH(2)) u_dut2 (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start2),
    .a         (a2),
    .sh_amt    (sh2),
    .busy      (busy2),
    .done      (done2),
    .d         (d2),
    .dbg_state (dbg2)
  );

  // scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  int           m_rem  = 0;   // busy cycles left, counting the done cycle
  logic [W-1:0] m_d    = '0;
  logic [W-1:0] m_pend = '0;
  int           m_n    = 0;

  function automatic logic [W-1:0] shl_ref(input logic [W-1:0] x, input int n);
    longint v;
    v = longint'(x) * (longint'(1) << n);
    return W'(v % (longint'(1) << W));
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_rem = 0;
      m_d   = '0;
    end else if (m_rem == 0) begin
      if (start === 1'b1) begin
        m_n    = (int'(sh_amt) >= W) ? W : int'(sh_amt);
        m_rem  = m_n + 1;
        m_pend = shl_ref(a, m_n);
        if (m_rem == 1) m_d = m_pend;
      end
    end else begin
      m_rem--;
      if (m_rem == 1) m_d = m_pend;
    end
  end

  // per-cycle compare
  bit chk_en = 1'b0;

  always @(negedge Clk) begin
    if (chk_en) begin
      check("cyc_busy", 32'(busy), 32'(m_rem > 0));
      check("cyc_done", 32'(done), 32'(m_rem == 1));
      check("cyc_d",    32'(d),    32'(m_d));
    end
  end

  // driver tasks (called at posedge+1)
  task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] sv);
    start  = 1'b1;
    a      = av;
    sh_amt = sv;
    @(posedge Clk); #1;
    start  = 1'b0;
    a      = W'($urandom);
    sh_amt = W'($urandom);
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      @(posedge Clk); #1;
      c++;
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] sv,
                        input logic [W-1:0] exp_d, input int exp_lat);
    int c;
    do_start(av, sv);
    check({nm, "_busy"}, 32'(busy), 32'd1);
    wait_done(c);
    check({nm, "_lat"}, 32'(c), 32'(exp_lat));
    check({nm, "_d"}, 32'(d), 32'(exp_d));
    @(posedge Clk); #1;
    check({nm, "_done_low"}, 32'(done), 32'd0);
    check({nm, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op2(input string nm, input logic [1:0] av, input logic [1:0] sv,
                         input logic [1:0] exp_d, input int exp_lat);
    int c;
    start2 = 1'b1;
    a2     = av;
    sh2    = sv;
    @(posedge Clk); #1;
    start2 = 1'b0;
    c = 0;
    while (done2 !== 1'b1 && c < 20) begin
      @(posedge Clk); #1;
      c++;
    end
    check({nm, "_lat"}, 32'(c), 32'(exp_lat));
    check({nm, "_d"}, 32'(d2), 32'(exp_d));
    @(posedge Clk); #1;
  endtask

  // stimulus
  initial begin
    int           c;
    int           pulses;
    logic [W-1:0] dval;
    int           sel;

    // 1. reset held with random inputs, then released with start=0
    Rst = 1'b0;
    @(posedge Clk); #1;
    chk_en = 1'b1;
    repeat (4) begin
      start  = 1'($urandom_range(0, 1));
      a      = W'($urandom);
      sh_amt = W'($urandom);
      @(posedge Clk); #1;
    end
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d",    32'(d),    32'd0);
    start = 1'b0;
    Rst   = 1'b1;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_d",    32'(d),    32'd0);

    // 2. basic shift
    run_op("t2", 8'h0B, 8'd3, 8'h58, 3);

    // 3. zero amount and clamped amounts (back-to-back restarts)
    run_op("t3_zero",  8'hA5, 8'd0,   8'hA5, 0);
    run_op("t3_eight", 8'hFF, 8'd8,   8'h00, 8);
    run_op("t3_200",   8'hFF, 8'd200, 8'h00, 8);

    // 6. restart right after done: the previous d holds until the new done
    run_op("t6_a", 8'h81, 8'd1, 8'h02, 1);
    do_start(8'h03, 8'd2);
    check("t6_hold", 32'(d), 32'h02);
    wait_done(c);
    check("t6_lat", 32'(c), 32'd2);
    check("t6_d", 32'(d), 32'h0C);
    @(posedge Clk); #1;

    // 4. a start while busy is ignored
    do_start(8'h13, 8'd5);
    @(posedge Clk); #1;
    start  = 1'b1;
    a      = 8'hFF;
    sh_amt = 8'd1;
    @(posedge Clk); #1;
    start  = 1'b0;
    pulses = 0;
    dval   = '0;
    repeat (12) begin
      if (done === 1'b1) begin
        pulses++;
        dval = d;
      end
      @(posedge Clk); #1;
    end
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_d", 32'(dval), 32'h60);

    // 5. reset two cycles into a run
    do_start(8'h5A, 8'd6);
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_d",    32'(d),    32'd0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    run_op("t5_after", 8'h01, 8'd7, 8'h80, 7);

    // randomized traffic, including starts while busy and occasional resets
    repeat (600) begin
      start  = ($urandom_range(0, 3) == 0);
      a      = W'($urandom);
      sel    = $urandom_range(0, 9);
      sh_amt = (sel == 0) ? W'($urandom_range(9, 255)) : W'($urandom_range(0, 8));
      if ($urandom_range(0, 99) == 0) begin
        Rst = 1'b0;
        #2;
        Rst = 1'b1;
      end
      @(posedge Clk); #1;
    end
    start = 1'b0;
    repeat (12) begin
      @(posedge Clk); #1;
    end

    // 6. narrow width
    run_op2("w2_one",   2'b01, 2'd1, 2'b10, 1);
    run_op2("w2_three", 2'b01, 2'd3, 2'b00, 2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
